// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared CPU word/opcode types plus the fetch unit state encoding.
package cpu_types_pkg;
   typedef logic [31:0] word_t;
   typedef logic [5:0]  opcode_t;
   localparam opcode_t HALT = 6'h3F;
   typedef enum logic [1:0] {FETCH, BUFFERED, HALTED} fetch_state_t;
   function automatic logic is_halt(input word_t w);
      return w[31:26] == HALT;
   endfunction
endpackage

// File: rtl/fetch_if.sv
// fetch_if: bundle of fetch unit signals with views for the unit and its driver.
interface fetch_if;
   import cpu_types_pkg::*;
   word_t imem_addr, imemload, iaddr, if_instr, if_npc;
   logic  ihit, stall, flush, iREN, pc_halt, if_valid;
   modport fetch (input imem_addr, ihit, imemload, stall, flush,
                  output iREN, iaddr, pc_halt, if_valid, if_instr, if_npc);
   modport tb (output imem_addr, ihit, imemload, stall, flush,
               input iREN, iaddr, pc_halt, if_valid, if_instr, if_npc);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with IF/ID register, one-entry stall buffer and HALT detection.
module fetch_unit
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  nRST,
   input  word_t imem_addr,
   input  logic  ihit,
   input  word_t imemload,
   input  logic  stall,
   input  logic  flush,
   output logic  iREN,
   output word_t iaddr,
   output logic  pc_halt,
   output logic  if_valid,
   output word_t if_instr,
   output word_t if_npc
);
   fetch_state_t state_q, state_d;
   logic  if_valid_q, if_valid_d;
   word_t if_instr_q, if_instr_d, if_npc_q, if_npc_d;
   word_t hold_instr_q, hold_instr_d, hold_npc_q, hold_npc_d;
   word_t npc;
   assign npc      = imem_addr + 32'd4;
   assign iaddr    = imem_addr;
   assign iREN     = nRST && state_q == FETCH;
   // A hit in FETCH lets the PC advance even if the word lands in the stall buffer.
   assign pc_halt  = !nRST || (!flush && !(state_q == FETCH && ihit));
   assign if_valid = if_valid_q;
   assign if_instr = if_instr_q;
   assign if_npc   = if_npc_q;
   always_comb begin
      state_d      = state_q;
      if_valid_d   = if_valid_q;
      if_instr_d   = if_instr_q;
      if_npc_d     = if_npc_q;
      hold_instr_d = hold_instr_q;
      hold_npc_d   = hold_npc_q;
      if (flush) begin
         state_d      = FETCH;
         if_valid_d   = 1'b0;
         if_instr_d   = '0;
         if_npc_d     = '0;
         hold_instr_d = '0;
         hold_npc_d   = '0;
      end else begin
         case (state_q)
            FETCH: begin
               if (ihit && !stall) begin
                  if_valid_d = 1'b1;
                  if_instr_d = imemload;
                  if_npc_d   = npc;
                  state_d    = is_halt(imemload) ? HALTED : FETCH;
               end else if (ihit) begin
                  hold_instr_d = imemload;
                  hold_npc_d   = npc;
                  state_d      = BUFFERED;
               end else if (!stall) begin
                  if_valid_d = 1'b0;
               end
            end
            BUFFERED: begin
               if (!stall) begin
                  if_valid_d = 1'b1;
                  if_instr_d = hold_instr_q;
                  if_npc_d   = hold_npc_q;
                  state_d    = is_halt(hold_instr_q) ? HALTED : FETCH;
               end
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_q      <= FETCH;
         if_valid_q   <= 1'b0;
         if_instr_q   <= '0;
         if_npc_q     <= '0;
         hold_instr_q <= '0;
         hold_npc_q   <= '0;
      end else begin
         state_q      <= state_d;
         if_valid_q   <= if_valid_d;
         if_instr_q   <= if_instr_d;
         if_npc_q     <= if_npc_d;
         hold_instr_q <= hold_instr_d;
         hold_npc_q   <= hold_npc_d;
      end
   end
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scoreboard bench for fetch_unit.
module tb_fetch_unit;
   import cpu_types_pkg::*;
   typedef struct packed {logic v; logic [31:0] i; logic [31:0] n;} ent_t;
   logic clk = 1'b0, nrst = 1'b0;
   int   tests = 0, fails = 0;
   ent_t exp_q[$];
   ent_t e;
   fetch_if fif();
   fetch_unit dut (
      .CLK(clk), .nRST(nrst), .imem_addr(fif.imem_addr), .ihit(fif.ihit),
      .imemload(fif.imemload), .stall(fif.stall), .flush(fif.flush),
      .iREN(fif.iREN), .iaddr(fif.iaddr), .pc_halt(fif.pc_halt),
      .if_valid(fif.if_valid), .if_instr(fif.if_instr), .if_npc(fif.if_npc)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic drive(input logic [31:0] a, input logic h, input logic [31:0] d, input logic s, input logic f);
      fif.imem_addr = a;
      fif.ihit      = h;
      fif.imemload  = d;
      fif.stall     = s;
      fif.flush     = f;
   endtask
   task automatic push(input logic v, input logic [31:0] i, input logic [31:0] n);
      exp_q.push_back({v, i, n});
   endtask
   task automatic pop_chk(input string tag);
      if (exp_q.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL %s scoreboard empty observed=%h expected=entry", tag, fif.if_instr);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_valid"}, {31'b0, fif.if_valid}, {31'b0, e.v});
         chk({tag, "_instr"}, fif.if_instr, e.i);
         chk({tag, "_npc"}, fif.if_npc, e.n);
      end
   endtask
   task automatic chk_ctl(input string tag, input logic iren, input logic halt);
      chk({tag, "_iREN"}, {31'b0, fif.iREN}, {31'b0, iren});
      chk({tag, "_pc_halt"}, {31'b0, fif.pc_halt}, {31'b0, halt});
   endtask
   initial begin
      drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk_ctl("rst", 1'b0, 1'b1);
      push(1'b0, 32'h0, 32'h0);
      pop_chk("rst");
      chk("rst_iaddr", fif.iaddr, 32'h0);
      tick;
      tick;
      @(negedge clk);
      nrst = 1'b1;
      #1;
      chk_ctl("release", 1'b1, 1'b1);
      drive(32'h0, 1'b1, 32'h20010005, 1'b0, 1'b0);
      #1;
      chk_ctl("first_accept", 1'b1, 1'b0);
      push(1'b1, 32'h20010005, 32'h4);
      tick;
      pop_chk("first");
      drive(32'h4, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk_ctl("miss", 1'b1, 1'b1);
      chk("iaddr", fif.iaddr, 32'h4);
      push(1'b0, 32'h20010005, 32'h4);
      tick;
      pop_chk("miss_clear");
      drive(32'h8, 1'b1, 32'h8C220000, 1'b1, 1'b0);
      #1;
      chk_ctl("stall_accept", 1'b1, 1'b0);
      tick;
      drive(32'hC, 1'b0, 32'h0, 1'b1, 1'b0);
      #1;
      chk_ctl("buf1", 1'b0, 1'b1);
      push(1'b0, 32'h20010005, 32'h4);
      pop_chk("buf1_hold");
      tick;
      chk_ctl("buf2", 1'b0, 1'b1);
      push(1'b0, 32'h20010005, 32'h4);
      pop_chk("buf2_hold");
      fif.stall = 1'b0;
      #1;
      chk_ctl("buf_drain", 1'b0, 1'b1);
      push(1'b1, 32'h8C220000, 32'hC);
      tick;
      pop_chk("buf_out");
      chk_ctl("after_buf", 1'b1, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive(32'h10 + 4 * k, 1'b1, 32'h00221820 + k, 1'b0, 1'b0);
         push(1'b1, 32'h00221820 + k, 32'h14 + 4 * k);
         tick;
         pop_chk("b2b");
      end
      drive(32'h1C, 1'b1, 32'hDEADBEEF, 1'b1, 1'b1);
      #1;
      chk_ctl("flush", 1'b1, 1'b0);
      push(1'b0, 32'h0, 32'h0);
      tick;
      pop_chk("flush");
      drive(32'h1C, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk_ctl("post_flush", 1'b1, 1'b1);
      drive(32'h18, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0);
      push(1'b1, 32'hFFFFFFFF, 32'h1C);
      tick;
      pop_chk("halt_in");
      drive(32'h1C, 1'b1, 32'h11111111, 1'b0, 1'b0);
      for (int k = 0; k < 10; k++) begin
         chk_ctl("halted", 1'b0, 1'b1);
         chk("halted_instr", fif.if_instr, 32'hFFFFFFFF);
         tick;
      end
      fif.flush = 1'b1;
      #1;
      chk_ctl("halt_flush", 1'b0, 1'b0);
      push(1'b0, 32'h0, 32'h0);
      tick;
      pop_chk("halt_exit");
      drive(32'h0, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk_ctl("halt_exit", 1'b1, 1'b1);
      drive(32'h20, 1'b1, 32'h12345678, 1'b1, 1'b0);
      tick;
      drive(32'h24, 1'b0, 32'h0, 1'b0, 1'b0);
      #1;
      chk_ctl("pre_rst_buf", 1'b0, 1'b1);
      #1;
      nrst = 1'b0;
      #1;
      chk_ctl("async_rst", 1'b0, 1'b1);
      push(1'b0, 32'h0, 32'h0);
      pop_chk("async_rst");
      #2;
      nrst = 1'b1;
      #1;
      chk_ctl("rerelease", 1'b1, 1'b1);
      push(1'b0, 32'h0, 32'h0);
      tick;
      pop_chk("buf_discarded");
      drive(32'hFFFFFFFC, 1'b1, 32'h3C010001, 1'b0, 1'b0);
      push(1'b1, 32'h3C010001, 32'h0);
      tick;
      pop_chk("wrap");
      drive(32'h40, 1'b1, 32'hFC000000, 1'b1, 1'b0);
      tick;
      fif.stall = 1'b0;
      fif.ihit  = 1'b0;
      push(1'b1, 32'hFC000000, 32'h44);
      tick;
      pop_chk("buf_halt");
      chk_ctl("buf_halted", 1'b0, 1'b1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have one clock and one reset: CLK  in  1  rising-edge clock; nRST  in  1  asynchronous, active-low reset.
REQ-002 SHALL have ports: imem_addr  in  word_t  current PC from pc; ihit  in  1  icache hit for iaddr; imemload  in  word_t  icache data.
REQ-003 SHALL have ports: stall  in  1  hazard unit holds IF/ID; flush  in  1  squash IF/ID, PC redirected this cycle.
REQ-004 SHALL have ports: iREN  out  1  icache read enable; iaddr  out  word_t  icache address; pc_halt  out  1  PC must hold this cycle.
REQ-005 SHALL have ports: if_valid  out  1  IF/ID holds live instruction; if_instr  out  word_t  IF/ID instruction; if_npc  out  word_t  IF/ID PC+4.
REQ-006 SHALL expose the ports through interface fetch_if, with modports fetch and tb.

Function
REQ-007 SHALL implement states FETCH, BUFFERED, HALTED.
REQ-008 SHALL drive iaddr = imem_addr combinationally in all states.
REQ-009 SHALL drive iREN = 1 only in FETCH with nRST high; 0 in BUFFERED and HALTED.
REQ-010 "accept" SHALL mean state FETCH and ihit=1 and flush=0.
REQ-011 On accept with stall=0: SHALL load IF/ID {valid=1, instr=imemload, npc=imem_addr+4} and drive pc_halt=0; state remains FETCH.
REQ-012 On accept with stall=1: SHALL capture {imemload, imem_addr+4} into a one-entry buffer, hold IF/ID, drive pc_halt=0, and go to BUFFERED.
REQ-013 In FETCH without accept and without flush: SHALL drive pc_halt=1 and hold IF/ID if stall=1, else clear if_valid.
REQ-014 In BUFFERED with stall=0 and flush=0: SHALL move the buffer into IF/ID (valid=1), drive pc_halt=1, and go to FETCH; with stall=1, SHALL hold everything.
REQ-015 When a HALT-opcode instruction (instr[31:26]==HALT) enters IF/ID by either path: SHALL go to HALTED.
REQ-016 In HALTED: SHALL drive pc_halt=1 and hold IF/ID; exit only via flush or reset.
REQ-017 flush=1 in any state SHALL take priority over stall and ihit: clear IF/ID to {0,0,0}, discard the buffer, ignore imemload, drive pc_halt=0, and go to FETCH.
REQ-018 npc arithmetic SHALL be 32-bit modulo: imem_addr 0xFFFFFFFC yields npc 0x00000000.
REQ-019 SHALL have a latency of one cycle from accept to if_valid=1; back-to-back hits with stall=0 SHALL sustain one instruction per cycle.

Reset
REQ-020 While nRST=0: SHALL hold state=FETCH, if_valid=0, if_instr=0, if_npc=0, buffer empty, iREN=0, pc_halt=1.
REQ-021 Reset asserted mid-operation, including in BUFFERED or HALTED, SHALL discard all held instructions immediately and asynchronously.
REQ-022 The first rising CLK edge after nRST deasserts SHALL see iREN=1.

Structure
REQ-023 The state enum fetch_state_t SHALL be added to cpu_types_pkg, reusing word_t and the opcode HALT constant.
REQ-024 The fetch_if interface SHALL reside in processors/include/fetch_if.vh.
REQ-025 No sub-module SHALL be used; the one-entry buffer and the IF/ID register are inline.

Verification
REQ-026 Reset release, imem_addr=0x0, ihit=1, imemload=0x20010005 -> next cycle if_valid=1, if_instr=0x20010005, if_npc=0x4; pc_halt=0 in the accept cycle.
REQ-027 Accept at 0x8 with stall=1 (2 cycles) -> BUFFERED, iREN=0, IF/ID unchanged; after stall drops -> if_instr=buffered word, if_npc=0xC, state FETCH.
REQ-028 flush=1 concurrent with ihit=1 and stall=1 -> if_valid=0, if_instr=0, imemload discarded, pc_halt=0, state FETCH.
REQ-029 imemload=0xFFFFFFFF accepted -> HALTED, iREN=0, pc_halt=1 held for 10 cycles; then flush=1 -> FETCH, if_valid=0.
REQ-030 nRST pulsed low mid-cycle while BUFFERED -> all outputs reach reset values before the next CLK edge; imem_addr=0xFFFFFFFC accept -> if_npc=0x0.
